// File: rtl/atb_pkg.sv
// Shared types and address helpers for the address target buffer.
// Word-address helpers split pc[31:2] into the table index and the tag.
package atb_pkg;

    localparam int unsigned PC_W  = 32;
    localparam int unsigned N     = 256;
    localparam int unsigned IDX_W = $clog2(N);
    localparam int unsigned TAG_W = 30 - IDX_W;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [PC_W-1:0]  tgt;
    } atb_entry_t;

    // Callers pass pc[31:2]; the byte offset never takes part in addressing.
    function automatic logic [IDX_W-1:0] pc_idx(input logic [PC_W-3:0] word_addr);
        return word_addr[IDX_W-1:0];
    endfunction

    function automatic logic [TAG_W-1:0] pc_tag(input logic [PC_W-3:0] word_addr);
        return word_addr[PC_W-3:IDX_W];
    endfunction

endpackage

// File: rtl/atb_if.sv
// Fetch lookup and retire install signals of the address target buffer.
// Master drives requests; slave is the buffer returning the prediction.
interface atb_if;
    import atb_pkg::*;

    logic            is_branch_i;
    logic [PC_W-1:0] pc_i;
    logic            retire_valid_i;
    logic [PC_W-1:0] retire_pc_i;
    logic [PC_W-1:0] retire_tgt_pc_i;
    logic            atb_valid_o;
    logic [PC_W-1:0] atb_tgt_pc_o;

    modport master (
        output is_branch_i, pc_i, retire_valid_i, retire_pc_i, retire_tgt_pc_i,
        input  atb_valid_o, atb_tgt_pc_o
    );

    modport slave (
        input  is_branch_i, pc_i, retire_valid_i, retire_pc_i, retire_tgt_pc_i,
        output atb_valid_o, atb_tgt_pc_o
    );

endinterface

// File: rtl/atb_ram.sv
// Tag/target storage: one asynchronous read port, one synchronous write port.
// Contents are deliberately not reset; validity lives in the top.
module atb_ram
    import atb_pkg::*;
#(
    parameter int unsigned DEPTH = N,
    parameter int unsigned AW    = IDX_W
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  atb_entry_t    wdata,
    input  logic [AW-1:0] raddr,
    output atb_entry_t    rdata
);

    atb_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/atb_unit.sv
// Direct-mapped branch target cache: same-cycle lookup for fetch,
// one-cycle install/overwrite from retire, no write-to-read bypass.
module atb_unit
    import atb_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    atb_if.slave  bus
);

    logic [N-1:0]     valid;
    logic [IDX_W-1:0] ridx;
    logic [IDX_W-1:0] widx;
    logic [TAG_W-1:0] rtag;
    logic             we;
    logic             hit;
    atb_entry_t       rd_entry;
    atb_entry_t       wr_entry;
    logic             unused_byte_offsets;

    assign ridx = pc_idx(bus.pc_i[PC_W-1:2]);
    assign rtag = pc_tag(bus.pc_i[PC_W-1:2]);
    assign widx = pc_idx(bus.retire_pc_i[PC_W-1:2]);

    assign unused_byte_offsets = ^{bus.pc_i[1:0], bus.retire_pc_i[1:0]};

    // Installs are suppressed while reset is held so no stale entry survives it.
    assign we = bus.retire_valid_i & ~reset;

    assign wr_entry.tag = pc_tag(bus.retire_pc_i[PC_W-1:2]);
    assign wr_entry.tgt = bus.retire_tgt_pc_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= '0;
        end else if (we) begin
            valid[widx] <= 1'b1;
        end
    end

    atb_ram #(
        .DEPTH (N),
        .AW    (IDX_W)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (widx),
        .wdata (wr_entry),
        .raddr (ridx),
        .rdata (rd_entry)
    );

    assign hit = bus.is_branch_i & ~reset & valid[ridx] & (rd_entry.tag == rtag);

    assign bus.atb_valid_o  = hit;
    assign bus.atb_tgt_pc_o = hit ? rd_entry.tgt : '0;

endmodule

// File: tb/tb_atb_unit.sv
// Directed and randomized checks of atb_unit against a per-index model
// that stores the full retired PC and compares word addresses.
module tb_atb_unit;

    logic clk = 1'b0;
    logic reset;

    atb_if bus ();

    atb_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    bit          mv   [256];
    logic [31:0] mpc  [256];
    logic [31:0] mtgt [256];

    function automatic int slot(input logic [31:0] pc);
        return int'((pc >> 2) % 256);
    endfunction

    task automatic model_clear();
        foreach (mv[i]) mv[i] = 1'b0;
    endtask

    // Expected prediction: same slot holds an entry whose word address equals pc's.
    task automatic check(input string name);
        logic        ev;
        logic [31:0] et;
        int          s;
        s  = slot(bus.pc_i);
        ev = 1'b0;
        et = 32'h0;
        if (bus.is_branch_i && !reset && mv[s] && (mpc[s][31:2] == bus.pc_i[31:2])) begin
            ev = 1'b1;
            et = mtgt[s];
        end
        tests++;
        assert ((bus.atb_valid_o === ev) && (bus.atb_tgt_pc_o === et))
        else begin
            fails++;
            $error("FAIL %s pc=%h: got valid=%b tgt=%h, expected valid=%b tgt=%h",
                   name, bus.pc_i, bus.atb_valid_o, bus.atb_tgt_pc_o, ev, et);
        end
    endtask

    task automatic lookup(input logic [31:0] pc, input logic br, input string name);
        bus.pc_i        = pc;
        bus.is_branch_i = br;
        #1;
        check(name);
    endtask

    // Advance one clock; a retire presented across the edge lands in the model.
    task automatic step();
        @(posedge clk);
        if (bus.retire_valid_i && !reset) begin
            mv[slot(bus.retire_pc_i)]   = 1'b1;
            mpc[slot(bus.retire_pc_i)]  = bus.retire_pc_i;
            mtgt[slot(bus.retire_pc_i)] = bus.retire_tgt_pc_i;
        end
        #1;
    endtask

    task automatic retire(input logic [31:0] pc, input logic [31:0] tgt);
        bus.retire_valid_i  = 1'b1;
        bus.retire_pc_i     = pc;
        bus.retire_tgt_pc_i = tgt;
        step();
        bus.retire_valid_i  = 1'b0;
    endtask

    initial begin
        logic [31:0] rpc;
        model_clear();
        reset               = 1'b1;
        bus.is_branch_i     = 1'b0;
        bus.pc_i            = '0;
        bus.retire_valid_i  = 1'b0;
        bus.retire_pc_i     = '0;
        bus.retire_tgt_pc_i = '0;
        #12;
        lookup(32'h10, 1'b1, "in_reset");
        @(negedge clk);
        reset = 1'b0;
        step();

        lookup(32'h10, 1'b1, "t1_empty");
        retire(32'h10, 32'h1000);
        lookup(32'h10, 1'b1, "t2_hit");
        retire(32'h20, 32'h2000);
        lookup(32'h20, 1'b1, "t3_hit20");
        lookup(32'h10, 1'b1, "t3_hit10");
        lookup(32'h30, 1'b1, "t4_miss");
        lookup(32'h30, 1'b0, "t4_nobranch");
        lookup(32'h10, 1'b0, "t4_nobranch_hit");
        lookup(32'h13, 1'b1, "byte_offset");

        retire(32'h410, 32'h3000);
        lookup(32'h10, 1'b1, "t5_alias_old");
        lookup(32'h410, 1'b1, "t5_alias_new");
        lookup(32'h3FC, 1'b1, "top_index_empty");
        retire(32'hFFFF_FFFC, 32'hDEAD_BEE0);
        lookup(32'hFFFF_FFFC, 1'b1, "top_index_hit");

        // Same-cycle write and lookup: pre-write contents, then the new entry.
        bus.retire_valid_i  = 1'b1;
        bus.retire_pc_i     = 32'h40;
        bus.retire_tgt_pc_i = 32'h4000;
        lookup(32'h40, 1'b1, "t6_same_cycle");
        step();
        bus.retire_valid_i  = 1'b0;
        lookup(32'h40, 1'b1, "t6_next_cycle");

        // Asynchronous reset mid-cycle, held across an attempted write.
        #2;
        reset = 1'b1;
        model_clear();
        lookup(32'h40, 1'b1, "t6_during_reset");
        bus.retire_valid_i  = 1'b1;
        bus.retire_pc_i     = 32'h50;
        bus.retire_tgt_pc_i = 32'h5000;
        step();
        bus.retire_valid_i  = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        step();
        lookup(32'h40, 1'b1, "t6_after_reset");
        lookup(32'h50, 1'b1, "write_in_reset");

        for (int i = 0; i < 300; i++) begin
            rpc = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 2)
                | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) rpc = $urandom;
            bus.retire_valid_i  = ($urandom_range(0, 1) == 1);
            bus.retire_pc_i     = rpc;
            bus.retire_tgt_pc_i = $urandom;
            rpc = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 2)
                | 32'($urandom_range(0, 3));
            lookup(rpc, ($urandom_range(0, 3) != 0), "rand_pre");
            step();
            bus.retire_valid_i = 1'b0;
            #1;
            check("rand_post");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
